// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
//
// Owns the PC, requests instruction words from instruction memory, and
// captures returned words into the IF/ID register. Opcode and funct of
// the captured word go straight to the downstream control unit.
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   RST          synchronous active-high reset
//   imemREN      instruction read request (low only when halted)
//   imemaddr     instruction address (always the current PC)
//   ihit         imemload holds a valid word this cycle
//   imemload     returned instruction word
//   stall        hazard hold: freeze PC and IF/ID
//   redirect     taken branch/jump/jr resolved downstream
//   redirect_pc  target address for redirect (low two bits ignored)
//   halt         HALT decoded from the instruction in IF/ID
//   if_valid     IF/ID holds a real instruction
//   if_instr     IF/ID instruction word
//   if_pc        PC of if_instr
//   if_npc       if_pc + 4
//   opcode       if_instr[31:26]
//   funct        if_instr[5:0]
//   halted       sticky halt indication, cleared only by RST
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [31:0]       imemload,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pending_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_pc;

    // Wraps modulo 2^ADDR_W by truncation.
    assign pc_plus4  = pc + ADDR_W'(4);
    assign target_pc = redirect_pc & ~ADDR_W'(3);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    // A redirect without ihit still has the old request in
                    // flight; wait for it in SQUASH and drop it.
                    if (!ihit) begin
                        next_state = SQUASH;
                    end
                end else if (halt) begin
                    next_state = HALTED;
                end
            end
            SQUASH: begin
                if (ihit) begin
                    next_state = FETCH;
                end
            end
            HALTED: next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        imemREN  = (state != HALTED);
        halted   = (state == HALTED);
        imemaddr = pc;
        opcode   = if_instr[31:26];
        funct    = if_instr[5:0];
    end

    // PC and IF/ID datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc         <= PC_INIT[ADDR_W-1:0];
            pending_pc <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_npc     <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (ihit) begin
                            pc <= target_pc;
                        end else begin
                            pending_pc <= target_pc;
                        end
                    end else if (halt) begin
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        // Hold everything; the word is re-requested next cycle.
                    end else if (ihit) begin
                        if_instr <= imemload;
                        if_pc    <= pc;
                        if_npc   <= pc_plus4;
                        if_valid <= 1'b1;
                        pc       <= pc_plus4;
                    end else begin
                        if_valid <= 1'b0;
                    end
                end
                SQUASH: begin
                    if_valid <= 1'b0;
                    if (ihit) begin
                        // A redirect arriving with the squashed word's ihit
                        // is newer than pending_pc, so it takes precedence.
                        pc <= redirect ? target_pc : pending_pc;
                    end else if (redirect) begin
                        pending_pc <= target_pc;
                    end
                end
                default: begin
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        CLK;
    int unsigned n_checks;
    int unsigned n_fail;

    // Instance with PC_INIT = 0
    logic        RST, imemREN, ihit, stall, redirect, halt;
    logic [31:0] imemaddr, imemload, redirect_pc, if_instr, if_pc, if_npc;
    logic        if_valid, halted;
    logic [5:0]  opcode, funct;

    // Instance with PC_INIT at the top of the address space
    logic        w_rst, w_imemREN, w_ihit, w_stall, w_redirect, w_halt;
    logic [31:0] w_imemaddr, w_imemload, w_redirect_pc, w_if_instr, w_if_pc, w_if_npc;
    logic        w_if_valid, w_halted;
    logic [5:0]  w_opcode, w_funct;

    fetch_stage #(.PC_INIT(32'h00000000), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_npc(if_npc),
        .opcode(opcode), .funct(funct), .halted(halted)
    );

    fetch_stage #(.PC_INIT(32'hFFFFFFFC), .ADDR_W(32)) dut_w (
        .CLK(CLK), .RST(w_rst), .imemREN(w_imemREN), .imemaddr(w_imemaddr),
        .ihit(w_ihit), .imemload(w_imemload), .stall(w_stall), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .halt(w_halt), .if_valid(w_if_valid),
        .if_instr(w_if_instr), .if_pc(w_if_pc), .if_npc(w_if_npc),
        .opcode(w_opcode), .funct(w_funct), .halted(w_halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        w_rst = 1'b1; w_ihit = 1'b0; w_imemload = '0; w_stall = 1'b0;
        w_redirect = 1'b0; w_redirect_pc = '0; w_halt = 1'b0;
        #2;

        // Reset state
        step();
        check("rst_addr",   imemaddr, 32'h0);
        check("rst_ren",    {31'b0, imemREN}, 32'h1);
        check("rst_valid",  {31'b0, if_valid}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_instr",  if_instr, 32'h0);
        check("rst_pc",     if_pc, 32'h0);
        check("rst_npc",    if_npc, 32'h0);

        // Zero-wait fetch stream
        RST = 1'b0; ihit = 1'b1; imemload = 32'h8C010004;
        step();
        check("t1_pc0",    if_pc, 32'h0);
        check("t1_npc0",   if_npc, 32'h4);
        check("t1_op0",    {26'b0, opcode}, 32'h23);
        check("t1_valid0", {31'b0, if_valid}, 32'h1);
        check("t1_addr1",  imemaddr, 32'h4);
        imemload = 32'h00221820;
        step();
        check("t1_pc1",    if_pc, 32'h4);
        check("t1_npc1",   if_npc, 32'h8);
        check("t1_op1",    {26'b0, opcode}, 32'h00);
        check("t1_funct1", {26'b0, funct}, 32'h20);
        check("t1_addr2",  imemaddr, 32'h8);

        // Memory wait states at pc=8
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_addr",  imemaddr, 32'h8);
            check("t2_ren",   {31'b0, imemREN}, 32'h1);
            check("t2_valid", {31'b0, if_valid}, 32'h0);
        end
        ihit = 1'b1; imemload = 32'h3C030010;
        step();
        check("t2_pc",    if_pc, 32'h8);
        check("t2_npc",   if_npc, 32'hC);
        check("t2_op",    {26'b0, opcode}, 32'h0F);
        check("t2_valid", {31'b0, if_valid}, 32'h1);
        check("t2_addr",  imemaddr, 32'hC);

        // Stall holds PC and IF/ID even with ihit
        imemload = 32'h20000001;
        step();
        check("t3_pre_pc", if_pc, 32'hC);
        check("t3_addr",   imemaddr, 32'h10);
        stall = 1'b1; imemload = 32'hAAAAAAAA;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_st_addr",  imemaddr, 32'h10);
            check("t3_st_pc",    if_pc, 32'hC);
            check("t3_st_instr", if_instr, 32'h20000001);
            check("t3_st_valid", {31'b0, if_valid}, 32'h1);
        end
        stall = 1'b0; imemload = 32'h12345678;
        step();
        check("t3_rel_pc",    if_pc, 32'h10);
        check("t3_rel_instr", if_instr, 32'h12345678);
        check("t3_rel_addr",  imemaddr, 32'h14);

        // Redirect without ihit: SQUASH, old word dropped, low bits cleared
        redirect = 1'b1; redirect_pc = 32'h41; ihit = 1'b0;
        step();
        check("t4_sq_addr",  imemaddr, 32'h14);
        check("t4_sq_valid", {31'b0, if_valid}, 32'h0);
        redirect = 1'b0; halt = 1'b1; stall = 1'b1;
        step();
        check("t4_sq_addr2", imemaddr, 32'h14);
        check("t4_sq_ren",   {31'b0, imemREN}, 32'h1);
        check("t4_sq_halt",  {31'b0, halted}, 32'h0);
        halt = 1'b0; stall = 1'b0; ihit = 1'b1; imemload = 32'hDEADBEEF;
        step();
        check("t4_tgt_addr", imemaddr, 32'h40);
        check("t4_drop",     {31'b0, if_valid}, 32'h0);
        imemload = 32'h01234567;
        step();
        check("t4_tgt_pc",    if_pc, 32'h40);
        check("t4_tgt_valid", {31'b0, if_valid}, 32'h1);
        check("t4_tgt_next",  imemaddr, 32'h44);

        // Second redirect during SQUASH wins
        redirect = 1'b1; redirect_pc = 32'h60; ihit = 1'b0;
        step();
        check("t4b_addr", imemaddr, 32'h44);
        redirect_pc = 32'h80;
        step();
        check("t4b_addr2", imemaddr, 32'h44);
        redirect = 1'b0; ihit = 1'b1;
        step();
        check("t4b_tgt",   imemaddr, 32'h80);
        check("t4b_valid", {31'b0, if_valid}, 32'h0);

        // Redirect with ihit in FETCH: immediate target, word discarded
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        check("t4c_addr",  imemaddr, 32'h100);
        check("t4c_valid", {31'b0, if_valid}, 32'h0);

        // Halt is sticky until reset
        redirect = 1'b0; halt = 1'b1;
        step();
        check("t5_ren",    {31'b0, imemREN}, 32'h0);
        check("t5_halted", {31'b0, halted}, 32'h1);
        check("t5_valid",  {31'b0, if_valid}, 32'h0);
        check("t5_addr",   imemaddr, 32'h100);
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t5_h_addr",   imemaddr, 32'h100);
            check("t5_h_halted", {31'b0, halted}, 32'h1);
            check("t5_h_ren",    {31'b0, imemREN}, 32'h0);
            check("t5_h_valid",  {31'b0, if_valid}, 32'h0);
        end
        RST = 1'b1; redirect = 1'b0;
        step();
        check("t5_rst_halted", {31'b0, halted}, 32'h0);
        check("t5_rst_addr",   imemaddr, 32'h0);
        check("t5_rst_ren",    {31'b0, imemREN}, 32'h1);
        RST = 1'b0; ihit = 1'b0;

        // PC wrap from the top of the address space
        step();
        check("t6_rst_addr", w_imemaddr, 32'hFFFFFFFC);
        w_rst = 1'b0; w_ihit = 1'b1; w_imemload = 32'h11111111;
        step();
        check("t6_pc",   w_if_pc, 32'hFFFFFFFC);
        check("t6_npc",  w_if_npc, 32'h0);
        check("t6_addr", w_imemaddr, 32'h0);

        // Reset during SQUASH discards the pending redirect
        w_ihit = 1'b0; w_redirect = 1'b1; w_redirect_pc = 32'h300;
        step();
        check("t6_sq_addr", w_imemaddr, 32'h0);
        w_rst = 1'b1; w_redirect = 1'b0; w_ihit = 1'b1;
        step();
        check("t6_rst_addr2", w_imemaddr, 32'hFFFFFFFC);
        check("t6_rst_valid", {31'b0, w_if_valid}, 32'h0);
        w_rst = 1'b0; w_imemload = 32'h22222222;
        step();
        check("t6_post_pc",    w_if_pc, 32'hFFFFFFFC);
        check("t6_post_valid", {31'b0, w_if_valid}, 32'h1);
        check("t6_post_addr",  w_imemaddr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
